// File: rtl/dmem_requester.sv
// -----------------------------------------------------------------------------
// dmem_requester
//
// Processor-side initiator for data-memory transactions in the Y86-64 memory
// stage. It decodes the instruction's memory action, computes the address and
// write data, and issues one request over a valid/ready handshake. It then waits
// for the response from a variable-latency data memory and returns valM together
// with the instruction status.
//
// Parameters
//   ADDR_LIMIT  highest legal data address; anything above it is an ADR fault
//   TIMEOUT     WAIT cycles tolerated before the transaction is abandonded (1..255)
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               memory-stage operation valid, sampled only when idle
//   icode               instruction code
//   valE, valA, valP    ALU result, register operand A, next PC
//   instr_valid         decoded instruction is legal
//   imem_error          fetch address fault
//   busy                transaction in progress
//   done                one-cycle completion pulse, valM/stat valid
//   valM, stat          read data and status (1 AOK, 2 ADR, 3 INS, 4 HLT), held
//   mreq_valid/ready    request handshake
//   mreq_write          1 write, 0 read
//   mreq_addr/wdata     request address and write data
//   mresp_valid         response / write acknowledge
//   mresp_rdata         read data
// -----------------------------------------------------------------------------
module dmem_requester #(
  parameter logic [63:0] ADDR_LIMIT = 64'd8191,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  input  logic        instr_valid,
  input  logic        imem_error,
  output logic        busy,
  output logic        done,
  output logic [63:0] valM,
  output logic [2:0]  stat,
  output logic        mreq_valid,
  input  logic        mreq_ready,
  output logic        mreq_write,
  output logic [63:0] mreq_addr,
  output logic [63:0] mreq_wdata,
  input  logic        mresp_valid,
  input  logic [63:0] mresp_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_ADR = 3'd2;
  localparam logic [2:0] STAT_INS = 3'd3;
  localparam logic [2:0] STAT_HLT = 3'd4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_r;
  logic [7:0]  cnt_r;
  logic        busy_r;
  logic        done_r;
  logic [63:0] valm_r;
  logic [2:0]  stat_r;
  logic        mreq_valid_r;
  logic        mreq_write_r;
  logic [63:0] mreq_addr_r;
  logic [63:0] mreq_wdata_r;

  logic        acc_s;
  logic        wr_s;
  logic [63:0] addr_s;
  logic [63:0] wdata_s;
  logic [2:0]  stat_s;
  logic        issue_s;

  // Decode the memory action of the presented instruction.
  always_comb begin
    acc_s   = 1'b0;
    wr_s    = 1'b0;
    addr_s  = valE;
    wdata_s = 64'd0;
    case (icode)
      I_RMMOVQ: begin
        acc_s   = 1'b1;
        wr_s    = 1'b1;
        wdata_s = valA;
      end
      I_MRMOVQ: begin
        acc_s = 1'b1;
      end
      I_CALL: begin
        acc_s   = 1'b1;
        wr_s    = 1'b1;
        wdata_s = valP;
      end
      I_PUSHQ: begin
        acc_s   = 1'b1;
        wr_s    = 1'b1;
        wdata_s = valA;
      end
      I_RET, I_POPQ: begin
        acc_s  = 1'b1;
        addr_s = valA;
      end
      default: begin
        acc_s = 1'b0;
      end
    endcase
  end

  // Status before any memory traffic; halt outranks every fault.
  always_comb begin
    if (icode == I_HALT) begin
      stat_s = STAT_HLT;
    end else if (imem_error || (acc_s && (addr_s > ADDR_LIMIT))) begin
      stat_s = STAT_ADR;
    end else if (!instr_valid) begin
      stat_s = STAT_INS;
    end else begin
      stat_s = STAT_AOK;
    end
  end

  // Only a clean instruction that touches memory goes out on the bus.
  always_comb begin
    if (acc_s && (stat_s == STAT_AOK)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      cnt_r        <= 8'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      valm_r       <= 64'd0;
      stat_r       <= STAT_AOK;
      mreq_valid_r <= 1'b0;
      mreq_write_r <= 1'b0;
      mreq_addr_r  <= 64'd0;
      mreq_wdata_r <= 64'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            busy_r <= 1'b1;
            if (issue_s) begin
              state_r      <= S_REQ;
              mreq_valid_r <= 1'b1;
              mreq_write_r <= wr_s;
              mreq_addr_r  <= addr_s;
              mreq_wdata_r <= wdata_s;
            end else begin
              // Faulting or memory-free instructions finish without a request.
              state_r <= S_DONE;
              done_r  <= 1'b1;
              stat_r  <= stat_s;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_REQ: begin
          if (mreq_ready) begin
            state_r      <= S_WAIT;
            mreq_valid_r <= 1'b0;
            cnt_r        <= 8'd0;
          end else begin
            state_r <= S_REQ;
          end
        end
        S_WAIT: begin
          // A response arriving on the timeout cycle still counts as success.
          if (mresp_valid) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
            stat_r  <= STAT_AOK;
            if (!mreq_write_r) begin
              valm_r <= mresp_rdata;
            end else begin
              valm_r <= valm_r;
            end
          end else if (cnt_r == TIMEOUT_C) begin
            state_r <= S_DONE;
            done_r  <= 1'b1;
            stat_r  <= STAT_ADR;
          end else if (cnt_r != 8'hFF) begin
            cnt_r <= cnt_r + 8'd1;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r      <= S_IDLE;
          done_r       <= 1'b0;
          busy_r       <= 1'b0;
          mreq_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign valM       = valm_r;
  assign stat       = stat_r;
  assign mreq_valid = mreq_valid_r;
  assign mreq_write = mreq_write_r;
  assign mreq_addr  = mreq_addr_r;
  assign mreq_wdata = mreq_wdata_r;

  dmem_requester_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .busy       (busy_r),
    .done       (done_r),
    .mreq_valid (mreq_valid_r),
    .mreq_ready (mreq_ready),
    .mreq_write (mreq_write_r),
    .mreq_addr  (mreq_addr_r),
    .mreq_wdata (mreq_wdata_r)
  );

endmodule

// -----------------------------------------------------------------------------
// dmem_requester_chk
//
// Protocol properties of the requester outputs.
//
// Ports: clk, rst_n, busy, done, and the request channel (mreq_valid, mreq_ready,
// mreq_write, mreq_addr, mreq_wdata), all inputs.
// -----------------------------------------------------------------------------
module dmem_requester_chk (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        busy,
  input  logic        done,
  input  logic        mreq_valid,
  input  logic        mreq_ready,
  input  logic        mreq_write,
  input  logic [63:0] mreq_addr,
  input  logic [63:0] mreq_wdata
);

  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);

  a_done_busy: assert property (@(posedge clk) disable iff (!rst_n)
    done |-> busy);

  a_req_busy: assert property (@(posedge clk) disable iff (!rst_n)
    mreq_valid |-> busy);

  // A stalled request must keep its payload until it is accepted.
  a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (mreq_valid && !mreq_ready) |=> (mreq_valid && $stable(mreq_addr) &&
                                     $stable(mreq_wdata) && $stable(mreq_write)));

endmodule

// File: tb/tb_dmem_requester.sv
// -----------------------------------------------------------------------------
// tb_dmem_requester
//
// Directed bench for dmem_requester. Each transaction is described by its
// instruction fields plus the memory's ready delay and response offset. The
// expected cycle-by-cycle outputs come from a timeline worked out with plain
// arithmetic. A compare process checks every cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_requester;

  localparam int TMO = 15;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic        instr_valid, imem_error;
  logic        busy, done;
  logic [63:0] valM;
  logic [2:0]  stat;
  logic        mreq_valid, mreq_ready, mreq_write;
  logic [63:0] mreq_addr, mreq_wdata;
  logic        mresp_valid;
  logic [63:0] mresp_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic        chk_en;
  logic        exp_busy, exp_done, exp_mreq_valid, exp_write;
  logic [63:0] exp_addr, exp_wdata, exp_valM;
  logic [2:0]  exp_stat;
  logic [63:0] prev_valM;
  logic [2:0]  prev_stat;
  int          obs_dc;

  dmem_requester #(.ADDR_LIMIT(64'd8191), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
    .valE(valE), .valA(valA), .valP(valP),
    .instr_valid(instr_valid), .imem_error(imem_error),
    .busy(busy), .done(done), .valM(valM), .stat(stat),
    .mreq_valid(mreq_valid), .mreq_ready(mreq_ready), .mreq_write(mreq_write),
    .mreq_addr(mreq_addr), .mreq_wdata(mreq_wdata),
    .mresp_valid(mresp_valid), .mresp_rdata(mresp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, expv);
    end
  endtask

  // Per-cycle comparison against the timeline expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("done", 64'(done), 64'(exp_done));
      chk("mreq_valid", 64'(mreq_valid), 64'(exp_mreq_valid));
      if (exp_mreq_valid) begin
        chk("mreq_addr", mreq_addr, exp_addr);
        chk("mreq_write", 64'(mreq_write), 64'(exp_write));
        if (exp_write) chk("mreq_wdata", mreq_wdata, exp_wdata);
      end
      chk("stat", 64'(stat), 64'(exp_stat));
      chk("valM", valM, exp_valM);
    end
  end

  // One transaction. r = cycles ready is held low, d = response offset into
  // WAIT (negative: never), noise = start pulses while busy plus stray responses
  // before WAIT.
  task automatic run(input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va,
                     input logic [63:0] vp, input logic iv, input logic ime,
                     input int r, input int d, input logic [63:0] rd, input logic noise);
    logic        acc, wr, issue, resp_ok;
    logic [63:0] a, wd, f_valM;
    logic [2:0]  s0, f_stat;
    int          dc;
    acc = 1'b0; wr = 1'b0; a = ve; wd = 64'd0;
    if (ic == 4'h4 || ic == 4'hA) begin acc = 1'b1; wr = 1'b1; wd = va; end
    if (ic == 4'h8) begin acc = 1'b1; wr = 1'b1; wd = vp; end
    if (ic == 4'h5) acc = 1'b1;
    if (ic == 4'h9 || ic == 4'hB) begin acc = 1'b1; a = va; end
    if (ic == 4'h0) s0 = 3'd4;
    else if (ime || (acc && a > 64'd8191)) s0 = 3'd2;
    else if (!iv) s0 = 3'd3;
    else s0 = 3'd1;
    issue   = acc && (s0 == 3'd1);
    resp_ok = (d >= 0) && (d <= TMO);
    if (issue) dc = 2 + r + (resp_ok ? d : TMO) + 1;
    else dc = 1;
    f_stat = issue ? (resp_ok ? 3'd1 : 3'd2) : s0;
    f_valM = (issue && !wr && resp_ok) ? rd : prev_valM;
    obs_dc = -1;
    for (int k = 0; k <= dc + 1; k++) begin
      @(posedge clk); #1;
      if (done && obs_dc < 0) obs_dc = k;
      start       = (k == 0) || (noise && k >= 1 && k <= dc);
      icode       = ic;
      valE        = (k == 0) ? ve : ~ve;
      valA        = (k == 0) ? va : ~va;
      valP        = (k == 0) ? vp : ~vp;
      instr_valid = iv;
      imem_error  = ime;
      mreq_ready  = issue && (k == 1 + r);
      mresp_valid = ((d >= 0) && (k == 2 + r + d)) || (noise && k <= 1 + r);
      mresp_rdata = (k == 2 + r + d) ? rd : ~rd;
      exp_busy       = (k >= 1) && (k <= dc);
      exp_done       = (k == dc);
      exp_mreq_valid = issue && (k >= 1) && (k <= 1 + r);
      exp_write      = wr;
      exp_addr       = a;
      exp_wdata      = wd;
      exp_stat       = (k >= dc) ? f_stat : prev_stat;
      exp_valM       = (k >= dc) ? f_valM : prev_valM;
      chk_en         = 1'b1;
    end
    start = 1'b0; mreq_ready = 1'b0; mresp_valid = 1'b0;
    prev_stat = f_stat;
    prev_valM = f_valM;
  endtask

  initial begin
    chk_en = 1'b0; rst_n = 1'b0; start = 1'b0; icode = 4'h0;
    valE = 64'd0; valA = 64'd0; valP = 64'd0; instr_valid = 1'b1; imem_error = 1'b0;
    mreq_ready = 1'b0; mresp_valid = 1'b0; mresp_rdata = 64'd0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_mreq_valid = 1'b0; exp_write = 1'b0;
    exp_addr = 64'd0; exp_wdata = 64'd0; exp_valM = 64'd0; exp_stat = 3'd1;
    prev_stat = 3'd1; prev_valM = 64'd0; obs_dc = -1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_mreq_valid", 64'(mreq_valid), 64'd0);
    chk("rst_mreq_write", 64'(mreq_write), 64'd0);
    chk("rst_mreq_addr", mreq_addr, 64'd0);
    chk("rst_mreq_wdata", mreq_wdata, 64'd0);
    chk("rst_valM", valM, 64'd0);
    chk("rst_stat", 64'(stat), 64'd1);
    rst_n = 1'b1;

    // Reset in the middle of WAIT.
    @(posedge clk); #1; start = 1'b1; icode = 4'h5; valE = 64'h40;
    @(posedge clk); #1; start = 1'b0; mreq_ready = 1'b1;
    chk("pre_rst_req", 64'(mreq_valid), 64'd1);
    @(posedge clk); #1; mreq_ready = 1'b0;
    chk("pre_rst_wait_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait_busy", 64'(busy), 64'd0);
    chk("rst_wait_mreq_valid", 64'(mreq_valid), 64'd0);
    chk("rst_wait_stat", 64'(stat), 64'd1);
    chk("rst_wait_done", 64'(done), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Reset while a request is stalled.
    start = 1'b1; icode = 4'h8; valE = 64'h100; valP = 64'h2A;
    @(posedge clk); #1; start = 1'b0;
    chk("pre_rst_req2", 64'(mreq_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_mreq_valid", 64'(mreq_valid), 64'd0);
    chk("rst_req_busy", 64'(busy), 64'd0);
    chk("rst_req_addr", mreq_addr, 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // mrmovq read, response one cycle after handshake.
    run(4'h5, 64'h40, 64'h0, 64'h0, 1'b1, 1'b0, 0, 0, 64'hDEAD, 1'b0);
    chk("pin_mrmovq_done_cycle", 64'(obs_dc), 64'd3);
    chk("pin_mrmovq_valM", valM, 64'hDEAD);
    chk("pin_mrmovq_stat", 64'(stat), 64'd1);
    // call write with ready held low 3 cycles.
    run(4'h8, 64'h100, 64'h77, 64'h2A, 1'b1, 1'b0, 3, 0, 64'h1111, 1'b0);
    chk("pin_call_valM", valM, 64'hDEAD);
    // pushq just past the limit.
    run(4'hA, 64'd8192, 64'h5, 64'h0, 1'b1, 1'b0, 0, 0, 64'h0, 1'b0);
    chk("pin_pushq_done_cycle", 64'(obs_dc), 64'd1);
    chk("pin_pushq_stat", 64'(stat), 64'd2);
    // ret at the limit reads from valA.
    run(4'h9, 64'h5000, 64'd8191, 64'h0, 1'b1, 1'b0, 0, 2, 64'h1234, 1'b0);
    chk("pin_ret_valM", valM, 64'h1234);
    // mrmovq with no response times out.
    run(4'h5, 64'h80, 64'h0, 64'h0, 1'b1, 1'b0, 0, -1, 64'h0, 1'b0);
    chk("pin_timeout_done_cycle", 64'(obs_dc), 64'd18);
    chk("pin_timeout_stat", 64'(stat), 64'd2);
    // Response on the timeout cycle wins.
    run(4'h5, 64'h88, 64'h0, 64'h0, 1'b1, 1'b0, 0, 15, 64'hBEEF, 1'b0);
    chk("pin_late_stat", 64'(stat), 64'd1);
    chk("pin_late_valM", valM, 64'hBEEF);
    // halt outranks imem_error.
    run(4'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b1, 0, 0, 64'h0, 1'b0);
    chk("pin_hlt_stat", 64'(stat), 64'd4);
    // nop with illegal encoding.
    run(4'h1, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 0, 0, 64'h0, 1'b0);
    chk("pin_ins_stat", 64'(stat), 64'd3);
    // rmmovq with start pulses while busy and stray responses before WAIT.
    run(4'h4, 64'h80, 64'h55, 64'h0, 1'b1, 1'b0, 1, 3, 64'h9999, 1'b1);
    chk("pin_noise_done_cycle", 64'(obs_dc), 64'd7);
    chk("pin_noise_valM", valM, 64'hBEEF);
    // popq with illegal encoding.
    run(4'hB, 64'h0, 64'h10, 64'h0, 1'b0, 1'b0, 0, 0, 64'h0, 1'b0);
    // Huge address checked unsigned.
    run(4'h5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 1'b1, 1'b0, 0, 0, 64'h0, 1'b0);
    // In-range rmmovq with a fetch fault.
    run(4'h4, 64'h20, 64'h3, 64'h0, 1'b1, 1'b1, 0, 0, 64'h0, 1'b0);
    // Plain nop, then a normal read after everything.
    run(4'h1, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 0, 0, 64'h0, 1'b0);
    run(4'h5, 64'd8191, 64'h0, 64'h0, 1'b1, 1'b0, 2, 4, 64'hCAFE_F00D, 1'b0);

    chk_en = 1'b0;
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
